// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/double-click/long/repeat pulses.
// Every event output is a registered one-cycle pulse. held_o is the registered pressed level.
module button_event_decoder #(
  parameter int CNT_W      = 24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             btn_i,
  input  logic [CNT_W-1:0] long_ticks,
  input  logic [CNT_W-1:0] dbl_gap_ticks,
  input  logic [CNT_W-1:0] rpt_ticks,
  output logic             press_o,
  output logic             release_o,
  output logic             click_o,
  output logic             dclick_o,
  output logic             long_o,
  output logic             repeat_o,
  output logic             held_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   WIDE_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             p;
  logic             p_q;
  logic             rise;
  logic             fall;
  logic             hit_long;
  logic             hit_dbl;
  logic             hit_rpt;
  logic             cnt_clr;
  logic             click_nxt;
  logic             dclick_nxt;
  logic             long_nxt;
  logic             repeat_nxt;

  // Threshold compare is one bit wider so cnt+1 never wraps at saturation.
  function automatic logic hit(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] t);
    logic [CNT_W:0] c1;
    c1 = {1'b0, c} + WIDE_ONE;
    return (t != '0) && (c1 >= {1'b0, t});
  endfunction

  assign p        = btn_i ^ ACTIVE_LOW;
  assign rise     = p & ~p_q;
  assign fall     = ~p & p_q;
  assign held_o   = p_q;
  assign hit_long = hit(cnt, long_ticks);
  assign hit_dbl  = hit(cnt, dbl_gap_ticks);
  assign hit_rpt  = hit(cnt, rpt_ticks);
  assign cnt_clr  = (state_nxt != state) || repeat_nxt;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      p_q       <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      click_o   <= 1'b0;
      dclick_o  <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      p_q       <= p;
      press_o   <= rise;
      release_o <= fall;
      click_o   <= click_nxt;
      dclick_o  <= dclick_nxt;
      long_o    <= long_nxt;
      repeat_o  <= repeat_nxt;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Edges take priority over thresholds in every state that watches both.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_nxt = (dbl_gap_ticks == '0) ? IDLE : WAIT2;
        end else if (hit_long) begin
          state_nxt = LONG;
        end
      end
      WAIT2: begin
        if (rise)         state_nxt = PRESS2;
        else if (hit_dbl) state_nxt = IDLE;
      end
      PRESS2: begin
        if (fall) state_nxt = IDLE;
      end
      LONG: begin
        if (fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    click_nxt  = 1'b0;
    dclick_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      PRESS1: begin
        if (fall)          click_nxt = (dbl_gap_ticks == '0);
        else if (hit_long) long_nxt  = 1'b1;
      end
      WAIT2: begin
        if (!rise && hit_dbl) click_nxt = 1'b1;
      end
      PRESS2: begin
        if (fall) dclick_nxt = 1'b1;
      end
      LONG: begin
        if (!fall && hit_rpt) repeat_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: expected (cycle, event) pairs are queued from the stimulus timing
// and matched in order against the pulses the decoder emits.
module tb_button_event_decoder;

  localparam int CNT_W = 24;
  localparam int EV_PRS = 1, EV_REL = 2, EV_CLK = 3, EV_DCK = 4, EV_LNG = 5, EV_RPT = 6;

  logic             sysclk;
  logic             reset_n;
  logic             btn_i;
  logic [CNT_W-1:0] long_ticks;
  logic [CNT_W-1:0] dbl_gap_ticks;
  logic [CNT_W-1:0] rpt_ticks;
  logic             press_o, release_o, click_o, dclick_o, long_o, repeat_o, held_o;
  logic [6:0]       outs;

  int               cyc = 0;
  int               n_cmp = 0;
  int               n_err = 0;
  bit               pressed_drv;
  logic             held_exp;
  logic [39:0]      sbq[$];

  button_event_decoder #(.CNT_W(CNT_W), .ACTIVE_LOW(1'b1)) dut (
    .sysclk        (sysclk),
    .reset_n       (reset_n),
    .btn_i         (btn_i),
    .long_ticks    (long_ticks),
    .dbl_gap_ticks (dbl_gap_ticks),
    .rpt_ticks     (rpt_ticks),
    .press_o       (press_o),
    .release_o     (release_o),
    .click_o       (click_o),
    .dclick_o      (dclick_o),
    .long_o        (long_o),
    .repeat_o      (repeat_o),
    .held_o        (held_o)
  );

  assign outs = {press_o, release_o, click_o, dclick_o, long_o, repeat_o, held_o};

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) held_exp <= 1'b0;
    else          held_exp <= pressed_drv;
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int code);
    sbq.push_back({c, 8'(code)});
  endtask

  task automatic drive(input bit pressed);
    pressed_drv = pressed;
    btn_i       = ~pressed;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic set_ticks(input int lt, input int dt, input int rt);
    long_ticks    = CNT_W'(lt);
    dbl_gap_ticks = CNT_W'(dt);
    rpt_ticks     = CNT_W'(rt);
  endtask

  // Observed pulses are taken in a fixed order within a cycle; expectations are pushed in the same order.
  always @(negedge sysclk) begin
    logic [5:0]  ev;
    logic [39:0] e;
    ev = {press_o, release_o, click_o, dclick_o, long_o, repeat_o};
    if (reset_n) begin
      chk("held", {39'd0, held_o}, {39'd0, held_exp});
      chk("excl", {39'd0, ($countones(ev[3:0]) <= 1)}, 40'd1);
      for (int i = 0; i < 6; i++) begin
        if (ev[5-i]) begin
          if (sbq.size() == 0) begin
            chk("unexpected", {cyc, 8'(i + 1)}, 40'd0);
          end else begin
            e = sbq.pop_front();
            chk("event", {cyc, 8'(i + 1)}, e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int p;
    int r;
    int p2;
    int r2;
    reset_n = 1'b0;
    drive(1'b0);
    set_ticks(10, 5, 4);
    idle(3);
    #1;
    chk("rst_outs", {33'd0, outs}, 40'd0);
    @(negedge sysclk);
    reset_n = 1'b1;

    // Idle button: nothing may fire.
    idle(20);
    chk("idle_outs", {33'd0, outs}, 40'd0);

    // Single click.
    p = cyc + 1; r = p + 3;
    push(p, EV_PRS); push(r, EV_REL); push(r + 5, EV_CLK);
    drive(1); idle(3); drive(0); idle(15);
    chk("sb_click", 40'(sbq.size()), 40'd0);

    // Double click.
    p = cyc + 1; r = p + 3; p2 = r + 2; r2 = p2 + 3;
    push(p, EV_PRS); push(r, EV_REL); push(p2, EV_PRS); push(r2, EV_REL); push(r2, EV_DCK);
    drive(1); idle(3); drive(0); idle(2); drive(1); idle(3); drive(0); idle(15);
    chk("sb_dclick", 40'(sbq.size()), 40'd0);

    // Long hold with auto-repeat; release on a repeat boundary suppresses that repeat.
    p = cyc + 1;
    push(p, EV_PRS); push(p + 10, EV_LNG);
    for (int k = 14; k < 30; k += 4) push(p + k, EV_RPT);
    push(p + 30, EV_REL);
    drive(1); idle(30); drive(0); idle(15);
    chk("sb_long", 40'(sbq.size()), 40'd0);

    // Release on the long threshold cycle counts as a short press.
    p = cyc + 1; r = p + 10;
    push(p, EV_PRS); push(r, EV_REL); push(r + 5, EV_CLK);
    drive(1); idle(10); drive(0); idle(15);
    chk("sb_long_edge", 40'(sbq.size()), 40'd0);

    // Second press on the gap timeout cycle wins over the click.
    p = cyc + 1; r = p + 3; p2 = r + 5; r2 = p2 + 2;
    push(p, EV_PRS); push(r, EV_REL); push(p2, EV_PRS); push(r2, EV_REL); push(r2, EV_DCK);
    drive(1); idle(3); drive(0); idle(5); drive(1); idle(2); drive(0); idle(15);
    chk("sb_gap_edge", 40'(sbq.size()), 40'd0);

    // long_ticks=0: long hold still ends as a click.
    set_ticks(0, 5, 4);
    p = cyc + 1; r = p + 50;
    push(p, EV_PRS); push(r, EV_REL); push(r + 5, EV_CLK);
    drive(1); idle(50); drive(0); idle(15);
    chk("sb_nolong", 40'(sbq.size()), 40'd0);

    // dbl_gap_ticks=0: click coincides with release.
    set_ticks(10, 0, 4);
    p = cyc + 1; r = p + 3;
    push(p, EV_PRS); push(r, EV_REL); push(r, EV_CLK);
    drive(1); idle(3); drive(0); idle(10);
    chk("sb_nodbl", 40'(sbq.size()), 40'd0);

    // rpt_ticks=0: long press without repeats.
    set_ticks(6, 5, 0);
    p = cyc + 1;
    push(p, EV_PRS); push(p + 6, EV_LNG); push(p + 20, EV_REL);
    drive(1); idle(20); drive(0); idle(15);
    chk("sb_norpt", 40'(sbq.size()), 40'd0);

    // Reset while in long-hold.
    set_ticks(10, 5, 4);
    p = cyc + 1;
    push(p, EV_PRS); push(p + 10, EV_LNG);
    drive(1); idle(12);
    chk("sb_pre_rst_long", 40'(sbq.size()), 40'd0);
    reset_n = 1'b0;
    drive(0);
    #1;
    chk("rst_long_outs", {33'd0, outs}, 40'd0);
    idle(4);
    reset_n = 1'b1;
    idle(20);
    chk("post_rst_long", 40'(sbq.size()), 40'd0);

    // Reset while waiting for a second press.
    p = cyc + 1; r = p + 3;
    push(p, EV_PRS); push(r, EV_REL);
    drive(1); idle(3); drive(0); idle(2);
    chk("sb_pre_rst_wait", 40'(sbq.size()), 40'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_wait_outs", {33'd0, outs}, 40'd0);
    idle(4);
    reset_n = 1'b1;
    idle(20);
    chk("post_rst_wait", 40'(sbq.size()), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
